// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache sitting between the
// fetch stage and the instruction port of the memory controller.
//   clk, rst              : clock, asynchronous active-low reset
//   if_req_i/if_addr_i    : fetch request and word-aligned byte address
//   flush_i               : invalidate every line
//   if_busy_o/if_done_o   : busy outside IDLE; one-cycle completion pulse
//   if_inst_o             : fetched instruction, held until the next pulse
//   mem_*                 : read-only rw_flag/busy/done handshake to memory
// Hits complete one edge after the LOOKUP edge; misses refill the whole line,
// words 0..N-1 in order, one outstanding read at a time.
module inst_cache #(
  parameter int INDEX_BIT = 6,
  parameter int BLOCK_BIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic        if_busy_o,
  output logic        if_done_o,
  output logic [31:0] if_inst_o,
  output logic [1:0]  mem_rw_flag_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_r_data_i,
  output logic [31:0] mem_w_data_o,
  output logic [3:0]  mem_w_mask_o,
  input  logic        mem_busy_i,
  input  logic        mem_done_i
);

  localparam int TAG_W = 32 - INDEX_BIT - BLOCK_BIT - 2;
  localparam int LINES = 1 << INDEX_BIT;
  localparam int WORDS = 1 << BLOCK_BIT;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [29:0]          req_addr_q;   // latched word address (byte bits dropped)
  logic [BLOCK_BIT-1:0] cnt_q;        // refill word counter
  logic                 abort_q;      // flush seen during this miss: keep line invalid
  logic [31:0]          cap_q;        // requested word captured during refill
  logic [LINES-1:0]     valid_q;

  // Tag/data storage is never reset; only the valid bits are.
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [31:0]          data_mem [LINES*WORDS];
  logic [TAG_W-1:0]     tag_rd_q;
  logic [31:0]          data_rd_q;

  logic [INDEX_BIT-1:0] req_index;
  logic [BLOCK_BIT-1:0] req_off;
  logic [INDEX_BIT-1:0] cur_index;
  logic [BLOCK_BIT-1:0] cur_off;
  logic [TAG_W-1:0]     cur_tag;
  logic                 hit;
  logic                 last_word;
  logic                 fill_we;
  logic                 unused_byte_bits;

  assign req_index = if_addr_i[BLOCK_BIT+2 +: INDEX_BIT];
  assign req_off   = if_addr_i[2 +: BLOCK_BIT];
  assign cur_index = req_addr_q[BLOCK_BIT +: INDEX_BIT];
  assign cur_off   = req_addr_q[0 +: BLOCK_BIT];
  assign cur_tag   = req_addr_q[29 -: TAG_W];

  // valid is read live so a flush on the request edge turns the lookup into a miss.
  assign hit       = valid_q[cur_index] && (tag_rd_q == cur_tag);
  assign last_word = (cnt_q == {BLOCK_BIT{1'b1}});
  assign fill_we   = (state_q == S_REFILL) && (mem_rw_flag_o == 2'b01) && mem_done_i;

  assign mem_w_data_o     = 32'd0;
  assign mem_w_mask_o     = 4'd0;
  assign unused_byte_bits = ^if_addr_i[1:0];

  // Storage: registered read launched from the incoming address while IDLE,
  // so tag and data are ready in LOOKUP.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      tag_rd_q  <= tag_mem[req_index];
      data_rd_q <= data_mem[{req_index, req_off}];
    end
    if (fill_we) begin
      data_mem[{cur_index, cnt_q}] <= mem_r_data_i;
      if (last_word) begin
        tag_mem[cur_index] <= cur_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      req_addr_q    <= '0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      cap_q         <= 32'd0;
      valid_q       <= '0;
      if_busy_o     <= 1'b0;
      if_done_o     <= 1'b0;
      if_inst_o     <= 32'd0;
      mem_rw_flag_o <= 2'b00;
      mem_addr_o    <= 32'd0;
    end else begin
      if_done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req_i) begin
            req_addr_q <= if_addr_i[31:2];
            if_busy_o  <= 1'b1;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if_inst_o <= data_rd_q;
            if_done_o <= 1'b1;
            if_busy_o <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q   <= '0;
            state_q <= S_REFILL;
            if (flush_i) begin
              abort_q <= 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (flush_i) begin
            abort_q <= 1'b1;
          end
          if (mem_rw_flag_o == 2'b01) begin
            // Read outstanding: hold flag and address until done, then drop
            // the flag so there is an idle cycle before the next read.
            if (mem_done_i) begin
              mem_rw_flag_o <= 2'b00;
              cnt_q         <= cnt_q + 1'b1;
              if (cnt_q == cur_off) begin
                cap_q <= mem_r_data_i;
              end
              if (last_word) begin
                state_q <= S_RESP;
              end
            end
          end else if (!mem_busy_i) begin
            mem_rw_flag_o <= 2'b01;
            mem_addr_o    <= {cur_tag, cur_index, cnt_q, 2'b00};
          end
        end
        S_RESP: begin
          if_inst_o <= cap_q;
          if_done_o <= 1'b1;
          if_busy_o <= 1'b0;
          abort_q   <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // A flush wins over a line becoming valid on the same edge.
      if (flush_i) begin
        valid_q <= '0;
      end else if (fill_we && last_word && !abort_q) begin
        valid_q[cur_index] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized bench for inst_cache. A behavioural memory
// controller answers reads with random latency and random busy; a line-level
// model (valid/tag per index) predicts hit or miss, the read sequence and the
// returned instruction for every fetch.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        if_busy_o;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic [1:0]  mem_rw_flag_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_r_data_i = 32'd0;
  logic [31:0] mem_w_data_o;
  logic [3:0]  mem_w_mask_o;
  logic        mem_busy_i = 1'b0;
  logic        mem_done_i = 1'b0;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .flush_i      (flush_i),
    .if_busy_o    (if_busy_o),
    .if_done_o    (if_done_o),
    .if_inst_o    (if_inst_o),
    .mem_rw_flag_o(mem_rw_flag_o),
    .mem_addr_o   (mem_addr_o),
    .mem_r_data_i (mem_r_data_i),
    .mem_w_data_o (mem_w_data_o),
    .mem_w_mask_o (mem_w_mask_o),
    .mem_busy_i   (mem_busy_i),
    .mem_done_i   (mem_done_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the address, salted per run.
  logic [31:0] salt;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Reference model: one valid flag and tag per line.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];

  task automatic model_flush();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Behavioural memory controller, acting on the falling edge.
  logic [31:0] read_log[$];
  logic [31:0] issue_addr = 32'd0;
  bit          in_flight = 1'b0;
  bit          force_busy = 1'b0;
  int          wait_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      in_flight  = 1'b0;
      mem_done_i = 1'b0;
      mem_busy_i = force_busy;
    end else begin
      mem_done_i   = 1'b0;
      mem_r_data_i = $urandom;
      if (mem_rw_flag_o != 2'b00 && mem_rw_flag_o != 2'b01)
        check_val("flag_legal", 32'(mem_rw_flag_o), 32'd1);
      if (mem_rw_flag_o == 2'b01) begin
        if (!in_flight) begin
          in_flight  = 1'b1;
          issue_addr = mem_addr_o;
          read_log.push_back(mem_addr_o);
          // mem_busy_i still holds the value the DUT sampled when it issued.
          check_val("issue_busy", 32'(mem_busy_i), 32'd0);
          wait_cnt = $urandom_range(0, 3);
        end else if (mem_addr_o !== issue_addr) begin
          check_val("addr_hold", mem_addr_o, issue_addr);
        end
        if (wait_cnt == 0) begin
          mem_done_i   = 1'b1;
          mem_r_data_i = mem_word(issue_addr);
          in_flight    = 1'b0;
          done_cnt++;
        end else begin
          wait_cnt--;
        end
      end else if (in_flight) begin
        check_val("flag_drop", 32'(mem_rw_flag_o), 32'd1);
        in_flight = 1'b0;
      end
      mem_busy_i = force_busy || in_flight || ($urandom_range(0, 3) == 0);
    end
  end

  task automatic flush_pulse();
    @(negedge clk); #1;
    flush_i = 1'b1;
    model_flush();
    @(negedge clk); #1;
    flush_i = 1'b0;
  endtask

  // One fetch transaction; optional flush with the request, flush after the
  // given number of memory dones, or forced memory busy for some cycles.
  task automatic fetch(input logic [31:0] a, input bit flush_with_req,
                       input int flush_after_done, input int busy_cycles);
    int   idx;
    logic [21:0] tg;
    bit   exp_hit;
    bit   got;
    bit   flushed;
    int   log0;
    int   d0;
    int   lat;
    idx = int'((a >> 4) % 64);
    tg  = 22'(a >> 10);
    @(negedge clk); #1;
    if (flush_with_req) begin
      flush_i = 1'b1;
      model_flush();
    end
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    log0 = read_log.size();
    d0   = done_cnt;
    if (busy_cycles > 0) force_busy = 1'b1;
    if_req_i  = 1'b1;
    if_addr_i = a;
    got = 1'b0;
    flushed = 1'b0;
    lat = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk); #1;
      if_req_i  = 1'b0;
      flush_i   = 1'b0;
      if_addr_i = $urandom;
      lat++;
      if (lat == 1) check_val("busy_hi", 32'(if_busy_o), 32'd1);
      if (busy_cycles > 0 && lat <= busy_cycles) begin
        check_val("busy_hold", 32'(mem_rw_flag_o), 32'd0);
        if (lat == busy_cycles) force_busy = 1'b0;
      end
      if (flush_after_done > 0 && !flushed && (done_cnt - d0) >= flush_after_done) begin
        flush_i = 1'b1;
        flushed = 1'b1;
        model_flush();
      end
      if (if_done_o) got = 1'b1;
    end
    force_busy = 1'b0;
    if (!got) begin
      check_val("timeout", 32'd0, 32'd1);
      flush_i = 1'b0;
      return;
    end
    if (exp_hit) begin
      check_val("hit_lat", 32'(lat), 32'd2);
      check_val("hit_reads", 32'(read_log.size() - log0), 32'd0);
    end else begin
      check_val("miss_reads", 32'(read_log.size() - log0), 32'd4);
      for (int k = 0; k < 4 && (log0 + k) < read_log.size(); k++)
        check_val("rd_addr", read_log[log0 + k], (a & ~32'hF) + 32'(4 * k));
      if (!flushed) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end
    check_val("inst", if_inst_o, mem_word(a));
    check_val("busy_lo", 32'(if_busy_o), 32'd0);
    $display("fetch %h hit=%0d lat=%0d inst=%h", a, exp_hit, lat, if_inst_o);
    @(negedge clk); #1;
    flush_i = 1'b0;
    check_val("done_pulse", 32'(if_done_o), 32'd0);
    check_val("inst_hold", if_inst_o, mem_word(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    model_flush();

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(if_busy_o), 32'd0);
    check_val("rst_done", 32'(if_done_o), 32'd0);
    check_val("rst_inst", if_inst_o, 32'd0);
    check_val("rst_flag", 32'(mem_rw_flag_o), 32'd0);
    check_val("rst_maddr", mem_addr_o, 32'd0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss, hit, flush, conflicts
    fetch(32'h0000_0108, 1'b0, 0, 0);
    fetch(32'h0000_010C, 1'b0, 0, 0);
    flush_pulse();
    fetch(32'h0000_010C, 1'b0, 0, 0);
    fetch(32'h0000_1108, 1'b0, 0, 0);
    fetch(32'h0000_0108, 1'b0, 0, 0);
    fetch(32'h0000_0104, 1'b0, 0, 0);

    // Flush mid-refill: instruction returned, line left invalid
    fetch(32'h0000_2040, 1'b0, 2, 0);
    fetch(32'h0000_2040, 1'b0, 0, 0);
    fetch(32'h0000_2044, 1'b0, 0, 0);

    // Flush together with the request: looks up as a miss
    fetch(32'h0000_2048, 1'b1, 0, 0);

    // Memory busy holds off the first read
    fetch(32'h0000_3000, 1'b0, 0, 5);

    // Asynchronous reset in the middle of a refill
    begin
      int d0;
      @(negedge clk); #1;
      d0 = done_cnt;
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_5210;
      @(negedge clk); #1;
      if_req_i = 1'b0;
      for (int c = 0; c < 200 && (done_cnt - d0) < 2; c++) @(negedge clk);
      check_val("rst_mid_reads", 32'((done_cnt - d0) >= 2), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_val("arst_flag", 32'(mem_rw_flag_o), 32'd0);
      check_val("arst_busy", 32'(if_busy_o), 32'd0);
      check_val("arst_done", 32'(if_done_o), 32'd0);
      model_flush();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      $display("reset mid-refill applied");
    end
    fetch(32'h0000_5210, 1'b0, 0, 0);
    fetch(32'h0000_5214, 1'b0, 0, 0);

    // Randomized traffic over a small address pool so lines hit and conflict
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      int r;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      r = $urandom_range(0, 19);
      if (r == 0) flush_pulse();
      fetch(a, (r == 1), (r == 2) ? $urandom_range(1, 4) : 0,
            (r == 3) ? $urandom_range(1, 4) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
